// File: rtl/apb_wait_slave_pkg.sv
// Shared widths and FSM state type for the APB wait-state slave.
package apb_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

endpackage

// File: rtl/apb_wait_slave_if.sv
// APB-style bus between a master and apb_wait_slave.
// sel/enable/write/addr/wdata/wait_cycles flow master->slave;
// rdata/ready flow slave->master.
interface apb_wait_slave_if
  import apb_pkg::*;
  ();

  logic [SEL_W-1:0]  sel;
  logic              enable;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [WAIT_W-1:0] wait_cycles;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (
    output sel, enable, write, addr, wdata, wait_cycles,
    input  rdata, ready
  );

  modport slave (
    input  sel, enable, write, addr, wdata, wait_cycles,
    output rdata, ready
  );

endinterface

// File: rtl/apb_wait_slave_regs.sv
// DEPTH x DATA_W register file with asynchronous clear.
// Ports: clk, reset, single write port (we_i, waddr_i, wdata_i),
// combinational read port (raddr_i -> rdata_o).
module apb_slave_regs
  import apb_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/apb_wait_slave.sv
// APB slave with a per-transfer programmable number of wait states.
// Ports: clk, reset (async, active-high), bus (apb_wait_slave_if.slave).
// IDLE captures a setup phase (sel hit, enable low), SETUP registers read
// data, ACCESS counts down wait states under enable and completes when the
// counter reaches zero. Losing sel in SETUP/ACCESS aborts the transfer.
module apb_wait_slave
  import apb_pkg::*;
#(
  parameter int unsigned SLAVE_ID = 1,
  parameter int unsigned DEPTH    = 16
) (
  input  logic             clk,
  input  logic             reset,
  apb_wait_slave_if.slave  bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              sel_hit;
  logic              in_range;
  logic              mem_we;
  logic              ready_c;
  logic [DATA_W-1:0] mem_rdata;

  assign sel_hit  = (bus.sel == SEL_W'(SLAVE_ID));
  assign in_range = ({1'b0, addr_q} < DEPTH_L);

  apb_slave_regs #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_regs (
    .clk     (clk),
    .reset   (reset),
    .we_i    (mem_we),
    .waddr_i (addr_q[AW-1:0]),
    .wdata_i (wdata_q),
    .raddr_i (addr_q[AW-1:0]),
    .rdata_o (mem_rdata)
  );

  // State and transfer context registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state, wait counter, read capture and write strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    // Ready is gated by sel so an abort in the final cycle never shows ready.
    ready_c = (state_q == ACCESS) && (cnt_q == '0) && sel_hit;

    case (state_q)
      IDLE: begin
        // enable high here is not a setup phase and is ignored.
        if (sel_hit && !bus.enable) begin
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          write_d = bus.write;
          cnt_d   = bus.wait_cycles;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (!sel_hit) begin
          state_d = IDLE;
        end else begin
          if (!write_q) rdata_d = in_range ? mem_rdata : '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!sel_hit) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          if (bus.enable) cnt_d = cnt_q - WAIT_W'(1);
        end else if (bus.enable) begin
          mem_we  = write_q && in_range;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ready = ready_c;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_apb_wait_slave.sv
module tb_apb_wait_slave;

  logic clk;
  logic reset;

  apb_wait_slave_if bus ();

  apb_wait_slave #(
    .SLAVE_ID (1),
    .DEPTH    (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every completing read is checked against the scoreboard.
  always @(negedge clk) begin
    if (!reset && bus.ready && bus.enable && !bus.write) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_read_completion", 1, 0);
      end else begin
        chk("read_rdata", int'(bus.rdata), int'(exp_q.pop_front()));
      end
    end
  end

  // mode 0: normal, expect ready after exp_lat enable cycles
  // mode 1: drop sel after k_after access cycles (abort)
  // mode 2: assert reset after k_after access cycles
  // mode 3: not selected, expect no ready
  task automatic xfer(input logic [1:0] s, input logic wr, input logic [7:0] a,
                      input logic [7:0] d, input logic [3:0] w, input int mode,
                      input int k_after, input int exp_lat, input string name);
    int n;
    bit done;
    bit hit_rst;
    int limit;
    limit = int'(w) + 3;
    if (!wr && mode == 0) exp_q.push_back(d);
    bus.sel = s;
    bus.enable = 1'b0;
    bus.write = wr;
    bus.addr = a;
    bus.wdata = wr ? d : 8'hC3;
    bus.wait_cycles = w;
    @(posedge clk); #1;
    bus.wait_cycles = 4'hF;
    @(posedge clk); #1;
    bus.enable = 1'b1;
    n = 0; done = 0; hit_rst = 0;
    for (int k = 0; k < limit && !done && !hit_rst; k++) begin
      @(negedge clk);
      n++;
      if (bus.ready) begin
        done = 1;
      end else if (mode == 2 && n == k_after) begin
        reset = 1'b1;
        #1;
        chk({name, "_rst_ready"}, int'(bus.ready), 0);
        chk({name, "_rst_rdata"}, int'(bus.rdata), 0);
        hit_rst = 1;
      end else begin
        @(posedge clk); #1;
        if (mode == 1 && n == k_after) bus.sel = 2'd0;
      end
    end
    if (done) begin
      @(posedge clk); #1;
    end
    bus.sel = 2'd0;
    bus.enable = 1'b0;
    if (hit_rst) begin
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
    end
    if (mode == 0) chk({name, "_latency"}, done ? n : -1, exp_lat);
    else           chk({name, "_no_ready"}, int'(done), 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.sel = 2'd0;
    bus.enable = 1'b0;
    bus.write = 1'b0;
    bus.addr = 8'h00;
    bus.wdata = 8'h00;
    bus.wait_cycles = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", int'(bus.ready), 0);
    chk("reset_rdata", int'(bus.rdata), 0);
    reset = 1'b0;

    // Zero-wait write then read
    xfer(2'd1, 1'b1, 8'h06, 8'h05, 4'd0, 0, 0, 1, "wr6");
    xfer(2'd1, 1'b0, 8'h06, 8'h05, 4'd0, 0, 0, 1, "rd6");
    // A write leaves rdata alone
    xfer(2'd1, 1'b1, 8'h07, 8'h33, 4'd0, 0, 0, 1, "wr7");
    chk("rdata_hold_after_write", int'(bus.rdata), 8'h05);

    // Five wait states
    xfer(2'd1, 1'b1, 8'h05, 8'h04, 4'd5, 0, 0, 6, "wr5");
    xfer(2'd1, 1'b0, 8'h05, 8'h04, 4'd5, 0, 0, 6, "rd5");

    // Abort by dropping sel
    xfer(2'd1, 1'b1, 8'h04, 8'hAA, 4'd3, 1, 1, 0, "wr4_abort");
    xfer(2'd1, 1'b0, 8'h04, 8'h00, 4'd3, 0, 0, 4, "rd4");

    // Out of range
    xfer(2'd1, 1'b1, 8'h20, 8'h77, 4'd0, 0, 0, 1, "wr20");
    xfer(2'd1, 1'b0, 8'h20, 8'h00, 4'd0, 0, 0, 1, "rd20");
    xfer(2'd1, 1'b0, 8'h00, 8'h00, 4'd0, 0, 0, 1, "rd0");

    // enable high in IDLE without a setup phase is ignored
    bus.sel = 2'd1; bus.enable = 1'b1; bus.write = 1'b1; bus.addr = 8'h06;
    bus.wdata = 8'hEE; bus.wait_cycles = 4'd0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_enable_ready", int'(bus.ready), 0);
    end
    @(posedge clk); #1;
    bus.sel = 2'd0; bus.enable = 1'b0;

    // Reset mid-transfer, with rdata non-zero beforehand
    xfer(2'd1, 1'b0, 8'h05, 8'h04, 4'd1, 0, 0, 2, "rd5_pre_rst");
    xfer(2'd1, 1'b1, 8'h03, 8'h09, 4'd4, 2, 2, 0, "wr3_rst");
    xfer(2'd1, 1'b0, 8'h03, 8'h00, 4'd0, 0, 0, 1, "rd3_after_rst");
    xfer(2'd1, 1'b0, 8'h06, 8'h00, 4'd0, 0, 0, 1, "rd6_after_rst");

    // Not selected, then back-to-back writes and reads
    xfer(2'd2, 1'b1, 8'h01, 8'h55, 4'd0, 3, 0, 0, "wr1_sel2");
    xfer(2'd1, 1'b1, 8'h01, 8'h11, 4'd0, 0, 0, 1, "wr1");
    xfer(2'd1, 1'b1, 8'h02, 8'h22, 4'd0, 0, 0, 1, "wr2");
    xfer(2'd1, 1'b0, 8'h01, 8'h11, 4'd0, 0, 0, 1, "rd1");
    xfer(2'd1, 1'b0, 8'h02, 8'h22, 4'd0, 0, 0, 1, "rd2");

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/apb_wait_slave.md
APB_WAIT_SLAVE -- requirements
Module: apb_wait_slave

Interface
REQ-001 Parameter SLAVE_ID, default 1: value of sel that selects this slave.
REQ-002 Parameter DEPTH, default 16: number of 8-bit storage locations, power of two, at most 256.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 sel  input  2  slave select; the slave is selected when sel == SLAVE_ID.
REQ-007 enable  input  1  APB access-phase strobe.
REQ-008 write  input  1  1 = write transfer, 0 = read transfer.
REQ-009 addr  input  8  byte address.
REQ-010 wdata  input  8  write data.
REQ-011 wait_cycles  input  4  number of wait states to insert; sampled only in the setup phase.
REQ-012 rdata  output  8  read data, valid while ready=1 on a read.
REQ-013 ready  output  1  transfer-complete indication.

Function
REQ-014 The FSM SHALL have three states:
- IDLE.
- SETUP: one cycle after a valid setup phase is captured.
- ACCESS: counts wait states.
REQ-015 In IDLE, the sampled condition sel==SLAVE_ID with enable=0 SHALL trigger the following on that edge:
- latch addr, write, wdata and wait_cycles into the internal counter;
- go to SETUP.
REQ-016 In SETUP, a read SHALL register mem[addr] into rdata.
REQ-017 In SETUP, addr >= DEPTH SHALL register rdata = 8'h00.
REQ-018 SETUP SHALL go to ACCESS unconditionally.
REQ-019 In ACCESS with enable=1 and counter != 0, the counter SHALL decrement while ready stays 0.
REQ-020 In ACCESS with counter == 0, ready SHALL be 1, decoded combinationally from state and counter.
REQ-021 On the edge where ready=1 and enable=1, a latched write with addr < DEPTH SHALL commit; the FSM SHALL return to IDLE.
REQ-022 Transfer latency SHALL be ready=1 on the (wait_cycles+1)-th cycle with enable=1 after setup.
REQ-023 Writes to addr >= DEPTH SHALL complete normally with no state change.
REQ-024 If sel != SLAVE_ID in SETUP or ACCESS, the transfer SHALL abort:
- no write is committed;
- ready stays 0;
- the FSM returns to IDLE.
REQ-025 enable=1 seen in IDLE without a preceding setup SHALL be ignored.
REQ-026 ready SHALL be 0 in every cycle other than the completing ACCESS cycle.
REQ-027 rdata SHALL hold its last value between transfers.
REQ-028 A write SHALL leave rdata unchanged.
REQ-029 Back-to-back transfers SHALL be supported.
- After returning to IDLE, a setup phase in the next cycle starts a new transfer.
- There are no dead cycles beyond IDLE.
REQ-030 wait_cycles changes after SETUP SHALL not affect the current transfer.
REQ-031 A read after a write to the same address SHALL return the new data.

Reset
REQ-032 Reset SHALL take effect immediately and asynchronously:
- FSM to IDLE;
- counter = 0;
- ready = 0;
- rdata = 8'h00;
- all DEPTH storage locations = 8'h00;
- latched address, data and write = 0.
REQ-033 Reset asserted mid-transfer SHALL discard the transfer with no write committed.
REQ-034 After reset deasserts, the first setup phase SHALL be accepted on the next rising edge.

Structure
REQ-035 Shared package apb_pkg SHALL hold:
- ADDR_W=8, DATA_W=8, SEL_W=2, WAIT_W=4;
- the FSM state enum (IDLE, SETUP, ACCESS).
REQ-036 Storage SHALL be a sub-module apb_slave_regs.
- Contents: DEPTH x 8 register array with asynchronous reset.
- Ports: single write port (we, waddr, wdata) and combinational read port (raddr, rdata).
REQ-037 The FSM and wait counter SHALL reside in apb_wait_slave.

Verification
REQ-038 Zero-wait write then read:
- Stimulus: wait_cycles=0, write addr=6 wdata=8'h05, then read addr=6.
- Response: ready=1 in the first enable cycle of each transfer; read rdata=8'h05.
REQ-039 Five-wait read:
- Stimulus: wait_cycles=5, write addr=5 data=8'h04, then read addr=5.
- Response: ready=0 for 5 enable cycles, ready=1 on the 6th; rdata=8'h04.
REQ-040 Abort:
- Stimulus: wait_cycles=3, write addr=4 data=8'hAA; sel driven to 0 after 1 access cycle; then read addr=4.
- Response: ready never asserted; the read returns 8'h00.
REQ-041 Out of range:
- Stimulus: DEPTH=16, write addr=8'h20 data=8'h77, then read addr=8'h20 and read addr=8'h00.
- Response: both reads complete with rdata=8'h00.
REQ-042 Reset mid-transfer:
- Stimulus: reset asserted during the ACCESS wait of a write addr=3 data=8'h09.
- Response: ready=0 and rdata=8'h00 immediately; a subsequent read of addr 3 returns 8'h00.
REQ-043 Select/back-to-back:
- Stimulus: sel=2 with SLAVE_ID=1 and a full transfer; then two back-to-back zero-wait writes, addr 1=8'h11 and addr 2=8'h22.
- Response: the sel=2 transfer gives no ready; both writes complete in consecutive transfers; reads return 8'h11 and 8'h22.
